// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, IF/ID field positions and fetch FSM encoding
package fetch_stage_pkg;
  localparam int PC_WIDTH = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int RD_MSB = 27;
  localparam int RD_LSB = 22;
  localparam int RS_MSB = 21;
  localparam int RS_LSB = 16;
  localparam int RT_MSB = 15;
  localparam int RT_LSB = 10;
  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;
endpackage

// File: rtl/fetch_stage_adder.sv
// full_adder_32: 32-bit ripple-carry adder built from one-bit full adders
//   i_a, i_b : operands
//   i_cin    : carry into bit 0
//   o_sum    : i_a + i_b + i_cin, modulo 2^32
module full_adder_32
  import fetch_stage_pkg::*;
(
  input  logic [PC_WIDTH-1:0] i_a,
  input  logic [PC_WIDTH-1:0] i_b,
  input  logic                i_cin,
  output logic [PC_WIDTH-1:0] o_sum
);
  logic [PC_WIDTH:0] w_c;
  assign w_c[0] = i_cin;
  for (genvar i = 0; i < PC_WIDTH; i++) begin : g_bit
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, IF/ID decode register, branch redirect and halt control
//   i_clock/i_reset        : clock, synchronous active-high reset
//   i_stall                : hold PC and IF/ID
//   i_branch_taken/_target : redirect PC, squash IF/ID, pulse o_flush_out
//   i_halt/i_resume        : enter/leave HALTED
//   o_imem_addr/i_imem_data: instruction memory port (same-cycle data)
//   o_*_id, o_pc_id, o_valid_id : IF/ID register
//   o_flush_out            : one-cycle pulse after a branch edge
//   o_issued_count         : number of instructions issued into IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_stall,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_halt,
  input  logic                i_resume,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic [PC_WIDTH-1:0] i_imem_data,
  output logic [3:0]          o_opcode_id,
  output logic [5:0]          o_rd_id,
  output logic [5:0]          o_rs_id,
  output logic [5:0]          o_rt_id,
  output logic [PC_WIDTH-1:0] o_pc_id,
  output logic                o_valid_id,
  output logic                o_flush_out,
  output logic [31:0]         o_issued_count
);
  state_t r_state, w_next_state;
  logic w_issue;
  logic [PC_WIDTH-1:0] r_pc, w_pc_inc;
  full_adder_32 u_inc (
    .i_a(r_pc),
    .i_b('0),
    .i_cin(1'b1),
    .o_sum(w_pc_inc)
  );
  always_ff @(posedge i_clock) r_state <= i_reset ? FETCH : w_next_state;
  // A branch redirects the PC but never changes the FSM state.
  always_comb
    w_next_state = i_branch_taken ? r_state :
                   r_state == FETCH ? (i_halt ? HALTED : FETCH) :
                   (i_resume && !i_halt) ? FETCH : HALTED;
  always_comb w_issue = r_state == FETCH && !i_branch_taken && !i_halt && !i_stall;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc           <= RESET_PC;
      o_valid_id     <= 1'b0;
      o_flush_out    <= 1'b0;
      o_issued_count <= '0;
      o_opcode_id    <= '0;
      o_rd_id        <= '0;
      o_rs_id        <= '0;
      o_rt_id        <= '0;
      o_pc_id        <= '0;
    end else begin
      r_pc        <= i_branch_taken ? i_branch_target : w_issue ? w_pc_inc : r_pc;
      // valid is already 0 in HALTED, so halt only needs to clear it on entry.
      o_valid_id  <= w_issue | (o_valid_id & ~i_branch_taken & ~i_halt);
      o_flush_out <= i_branch_taken;
      if (w_issue) begin
        o_opcode_id    <= i_imem_data[OP_MSB:OP_LSB];
        o_rd_id        <= i_imem_data[RD_MSB:RD_LSB];
        o_rs_id        <= i_imem_data[RS_MSB:RS_LSB];
        o_rt_id        <= i_imem_data[RT_MSB:RT_LSB];
        o_pc_id        <= r_pc;
        o_issued_count <= o_issued_count + 32'd1;
      end
    end
  end
  assign o_imem_addr = r_pc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a cycle-level reference model
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, stall, br, halt, resume;
  logic [31:0] tgt, data;
  logic [31:0] w_addr, w_pcid, w_cnt;
  logic [3:0]  w_op;
  logic [5:0]  w_rd, w_rs, w_rt;
  logic        w_valid, w_flush;
  logic        rst2;
  logic [31:0] w2_addr, w2_pcid, w2_cnt;
  logic [3:0]  w2_op;
  logic [5:0]  w2_rd, w2_rs, w2_rt;
  logic        w2_valid, w2_flush;
  fetch_stage dut (
    .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_branch_taken(br),
    .i_branch_target(tgt), .i_halt(halt), .i_resume(resume),
    .o_imem_addr(w_addr), .i_imem_data(data), .o_opcode_id(w_op),
    .o_rd_id(w_rd), .o_rs_id(w_rs), .o_rt_id(w_rt), .o_pc_id(w_pcid),
    .o_valid_id(w_valid), .o_flush_out(w_flush), .o_issued_count(w_cnt)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
    .i_clock(clk), .i_reset(rst2), .i_stall(1'b0), .i_branch_taken(1'b0),
    .i_branch_target(32'h0), .i_halt(1'b0), .i_resume(1'b0),
    .o_imem_addr(w2_addr), .i_imem_data(32'hA5A5_A5A5), .o_opcode_id(w2_op),
    .o_rd_id(w2_rd), .o_rs_id(w2_rs), .o_rt_id(w2_rt), .o_pc_id(w2_pcid),
    .o_valid_id(w2_valid), .o_flush_out(w2_flush), .o_issued_count(w2_cnt)
  );
  typedef struct {
    logic [31:0] addr, pcid, cnt;
    logic [3:0]  op;
    logic [5:0]  rd, rs, rt;
    logic        valid, flush;
  } exp_t;
  exp_t q[$];
  exp_t m, e;
  bit m_halted;
  int checks = 0, passed = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a === x) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, x);
  endtask
  // Reference model: one call = the architectural effect of one clock edge.
  task automatic step(bit r, bit s, bit b, logic [31:0] t, bit h, bit rs_, logic [31:0] d);
    rst = r; stall = s; br = b; tgt = t; halt = h; resume = rs_; data = d;
    if (r) begin
      m = '{addr: 32'h0, pcid: 0, cnt: 0, op: 0, rd: 0, rs: 0, rt: 0, valid: 0, flush: 0};
      m_halted = 0;
    end else if (b) begin
      m.addr = t; m.valid = 0; m.flush = 1;
    end else begin
      m.flush = 0;
      if (m_halted) begin
        if (rs_ && !h) m_halted = 0;
      end else if (h) begin
        m_halted = 1; m.valid = 0;
      end else if (!s) begin
        m.op = 4'(d >> 28); m.rd = 6'((d >> 22) % 64);
        m.rs = 6'((d >> 16) % 64); m.rt = 6'((d >> 10) % 64);
        m.pcid = m.addr; m.addr = m.addr + 1; m.valid = 1; m.cnt = m.cnt + 1;
      end
    end
    q.push_back(m);
    @(posedge clk);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_addr", w_addr, e.addr);
      chk("valid_id", {31'b0, w_valid}, {31'b0, e.valid});
      chk("flush_out", {31'b0, w_flush}, {31'b0, e.flush});
      chk("issued_count", w_cnt, e.cnt);
      chk("pc_id", w_pcid, e.pcid);
      chk("fields", {8'b0, w_op, w_rd, w_rs, w_rt}, {8'b0, e.op, e.rd, e.rs, e.rt});
    end
  end
  initial begin
    rst2 = 1'b1;
    @(posedge clk); @(negedge clk);
    rst2 = 1'b0;
    chk("rpc_reset_addr", w2_addr, 32'hFFFF_FFFF);
    chk("rpc_reset_valid", {31'b0, w2_valid}, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("rpc_first_pcid", w2_pcid, 32'hFFFF_FFFF);
    chk("rpc_first_valid", {31'b0, w2_valid}, 32'h1);
    @(posedge clk); @(negedge clk);
    chk("rpc_wrap_pcid", w2_pcid, 32'h0);
    chk("rpc_wrap_addr", w2_addr, 32'h1);
  end
  initial begin
    m_halted = 0;
    step(1, 0, 0, 0, 0, 0, 32'h1234_5678);
    repeat (3) step(0, 0, 0, 0, 0, 0, 32'h1234_5678);
    chk("dir_opcode", {28'b0, w_op}, 32'h1);
    chk("dir_rd", {26'b0, w_rd}, 32'h08);
    chk("dir_rs", {26'b0, w_rs}, 32'h34);
    chk("dir_rt", {26'b0, w_rt}, 32'h15);
    chk("dir_count", w_cnt, 32'd3);
    repeat (2) step(0, 0, 0, 0, 0, 0, $urandom);
    repeat (2) step(0, 1, 0, 0, 0, 0, $urandom);
    chk("dir_stall_addr", w_addr, 32'd5);
    step(0, 0, 0, 0, 0, 0, $urandom);
    chk("dir_stall_release", w_pcid, 32'd5);
    step(0, 1, 1, 32'h40, 0, 0, $urandom);
    chk("dir_br_flush", {31'b0, w_flush}, 32'h1);
    step(0, 0, 0, 0, 0, 0, $urandom);
    chk("dir_br_pcid", w_pcid, 32'h40);
    step(1, 0, 0, 0, 0, 0, $urandom);
    repeat (7) step(0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 1, 0, $urandom);
    repeat (4) step(0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 1, 1, $urandom);
    step(0, 0, 0, 0, 0, 1, $urandom);
    chk("dir_halt_addr", w_addr, 32'd7);
    step(0, 0, 0, 0, 0, 0, $urandom);
    chk("dir_resume_pcid", w_pcid, 32'd7);
    step(0, 0, 0, 0, 1, 0, $urandom);
    step(1, 0, 1, 32'h99, 0, 0, $urandom);
    chk("dir_rst_br_addr", w_addr, 32'h0);
    chk("dir_rst_br_flush", {31'b0, w_flush}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0);
    repeat (3) step(0, 0, 0, 0, 0, 0, $urandom);
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 10,
           ($urandom_range(3) == 0) ? 32'hFFFF_FFFD : $urandom, $urandom_range(99) < 8,
           $urandom_range(99) < 30, $urandom);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hold PC and IF/ID outputs unchanged.
REQ-005 branch_taken  input  1  redirect request resolved in WB stage.
REQ-006 branch_target  input  32  redirect PC value.
REQ-007 halt  input  1  request entry to HALTED.
REQ-008 resume  input  1  request exit from HALTED.
REQ-009 imem_addr  output  32  current PC to instruction memory, combinational from PC register.
REQ-010 imem_data  input  32  instruction at imem_addr, valid same cycle.
REQ-011 opcode_id  output  4  registered imem_data[31:28].
REQ-012 rd_id  output  6  registered imem_data[27:22].
REQ-013 rs_id  output  6  registered imem_data[21:16].
REQ-014 rt_id  output  6  registered imem_data[15:10].
REQ-015 pc_id  output  32  registered PC of the instruction in IF/ID.
REQ-016 valid_id  output  1  IF/ID holds a real instruction; 0 = bubble.
REQ-017 flush_out  output  1  registered one-cycle pulse telling ID/EX and EX/WB buffers to invalidate.
REQ-018 issued_count  output  32  count of instructions issued with valid_id=1.

Function
REQ-019 States FETCH, HALTED; the state register SHALL be the only FSM state.
REQ-020 Per-edge priority SHALL be: reset > branch_taken > halt > stall > normal fetch.
REQ-021 FETCH normal: PC <= PC+1 (mod 2^32, 32'hFFFF_FFFF wraps to 0); IF/ID <= decoded imem_data, pc_id <= PC, valid_id <= 1.
REQ-022 FETCH stall (no branch, no halt): PC, IF/ID fields, valid_id held; issued_count unchanged.
REQ-023 branch_taken (any state, stall or not): PC <= branch_target; valid_id <= 0; flush_out <= 1 on the next cycle only; state unchanged.
REQ-024 flush_out SHALL be 0 in every cycle not immediately following a branch_taken edge.
REQ-025 FETCH with halt=1 (no branch): state <= HALTED, PC held, valid_id <= 0.
REQ-026 HALTED: PC held, valid_id held at 0, IF/ID fields held, no issue; resume=1 with halt=0 -> FETCH, first fetch on the following edge.
REQ-027 resume SHALL be ignored in FETCH and whenever halt=1.
REQ-028 issued_count increments by 1 on each edge that loads valid_id <= 1; wraps at 2^32.
REQ-029 Bubble fields (valid_id=0) SHALL retain previous values; consumers qualify with valid_id.

Reset
REQ-030 On reset edge: PC <= RESET_PC, state <= FETCH, valid_id <= 0, flush_out <= 0, issued_count <= 0, opcode_id/rd_id/rs_id/rt_id/pc_id <= 0.
REQ-031 Reset mid-stall, mid-halt or concurrent with branch_taken SHALL override all other inputs; first valid instruction (pc_id=RESET_PC) appears two edges after reset deasserts... precisely: first edge with reset=0 loads IF/ID from RESET_PC.

Structure
REQ-032 Shared package SHALL hold PC_WIDTH=32, field bit positions for opcode/rd/rs/rt, and FETCH/HALTED encoding.
REQ-033 PC increment SHALL instantiate the existing full_adder_32 sub-module; no other sub-modules.

Verification
REQ-034 Reset, imem_data=32'h1234_5678 held, 3 free edges -> pc_id 0,1,2; opcode_id=4'h1, rd_id=6'h08, rs_id=6'h34, rt_id=6'h15; issued_count=3.
REQ-035 stall=1 for 2 edges at PC=5 -> imem_addr stays 5, pc_id/valid_id/issued_count unchanged; release -> pc_id=5.
REQ-036 branch_taken=1, branch_target=32'h40 with stall=1 -> next cycle imem_addr=32'h40, valid_id=0, flush_out=1; following cycle flush_out=0, pc_id=32'h40, valid_id=1.
REQ-037 halt pulse at PC=7 -> HALTED, valid_id=0 for 4 edges, imem_addr=7; resume with halt=1 -> no exit; resume alone -> next edge pc_id=7, valid_id=1.
REQ-038 RESET_PC=32'hFFFF_FFFF, 2 free edges -> pc_id FFFF_FFFF then 0000_0000.
REQ-039 reset asserted together with branch_taken during HALTED -> PC=RESET_PC, FETCH, flush_out=0, issued_count=0.
